// File: rtl/forth_pkg.sv
// rtl/forth_pkg.sv - shared Forth opcode, ASCII and FSM definitions
package forth_pkg;

    typedef enum logic [3:0] {
        OP_IDLE     = 4'd0,
        OP_PUSH     = 4'd1,
        OP_POP      = 4'd2,
        OP_ADD      = 4'd3,
        OP_SUBTRACT = 4'd4,
        OP_MULTIPLY = 4'd5,
        OP_DIVIDE   = 4'd6,
        OP_DUP      = 4'd7,
        OP_ROT      = 4'd8,
        OP_SWAP     = 4'd9
    } op_t;

    localparam int OP_LAST = 9;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_SEP  = 2'd2
    } state_t;

    // Length of a fixed-text word; PUSH is variable and handled separately.
    function automatic logic [2:0] word_len(input op_t op);
        logic [2:0] n;
        n = 3'd0;
        case (op)
            OP_POP, OP_ADD, OP_SUBTRACT, OP_MULTIPLY, OP_DIVIDE: n = 3'd1;
            OP_DUP, OP_ROT: n = 3'd3;
            OP_SWAP: n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    // Character at index idx, counting down so idx 0 is the last character.
    function automatic logic [7:0] word_char(input op_t op, input logic [1:0] idx);
        logic [7:0] c;
        c = ASCII_SPACE;
        case (op)
            OP_POP:      c = 8'h2E;
            OP_ADD:      c = 8'h2B;
            OP_SUBTRACT: c = 8'h2D;
            OP_MULTIPLY: c = 8'h2A;
            OP_DIVIDE:   c = 8'h2F;
            OP_DUP: begin
                case (idx)
                    2'd2:    c = 8'h44;
                    2'd1:    c = 8'h55;
                    default: c = 8'h50;
                endcase
            end
            OP_ROT: begin
                case (idx)
                    2'd2:    c = 8'h52;
                    2'd1:    c = 8'h4F;
                    default: c = 8'h54;
                endcase
            end
            OP_SWAP: begin
                case (idx)
                    2'd3:    c = 8'h53;
                    2'd2:    c = 8'h57;
                    2'd1:    c = 8'h41;
                    default: c = 8'h50;
                endcase
            end
            default: c = ASCII_SPACE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hex_digit.sv
// rtl/hex_digit.sv - nibble to uppercase ASCII hex character
module hex_digit
    import forth_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ASCII_ZERO + {4'd0, nibble};
        end else begin
            ascii = ASCII_A + {4'd0, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/opcode_to_word.sv
// rtl/opcode_to_word.sv - renders Forth opcodes as space-separated ASCII text
module opcode_to_word
    import forth_pkg::*;
#(
    parameter int DATA   = 32,
    parameter int OPCODE = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [OPCODE-1:0] i_opcode,
    input  logic [DATA-1:0]   i_data,
    output logic [7:0]        o_char,
    output logic              o_char_valid,
    input  logic              i_char_ready,
    output logic              o_err
);

    localparam int NIB  = DATA / 4;
    localparam int IDXW = $clog2(NIB + 4);

    state_t          state_q, state_d;
    op_t             op_q, op_d, op_in, sel_op;
    logic [DATA-1:0] data_q, data_d, sel_data;
    logic [IDXW-1:0] idx_q, idx_d, sel_idx, first_idx, digits;
    logic [7:0]      char_d, hex_char, cur_char;
    logic            char_valid_d, err_d, known;
    logic [3:0]      nib_sel;

    assign o_ready = (state_q == ST_IDLE) && !i_reset;
    assign op_in   = op_t'(i_opcode[3:0]);
    assign known   = (i_opcode <= OPCODE'(OP_LAST));

    // Leading-zero scan: position of the most significant non-zero nibble.
    always_comb begin
        digits = IDXW'(1);
        for (int i = 0; i < NIB; i++) begin
            if (i_data[i*4 +: 4] != 4'd0) begin
                digits = IDXW'(i + 1);
            end
        end
    end

    assign first_idx = (op_in == OP_PUSH) ? digits - IDXW'(1)
                                          : IDXW'(word_len(op_in)) - IDXW'(1);

    assign nib_sel = 4'(sel_data >> {sel_idx, 2'b00});

    hex_digit u_hex_digit (
        .nibble (nib_sel),
        .ascii  (hex_char)
    );

    assign cur_char = (sel_op == OP_PUSH) ? hex_char : word_char(sel_op, sel_idx[1:0]);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        data_d       = data_q;
        idx_d        = idx_q;
        char_d       = o_char;
        char_valid_d = o_char_valid;
        err_d        = 1'b0;
        // Outside IDLE the mux looks one character ahead so o_char can be registered.
        sel_op       = op_q;
        sel_data     = data_q;
        sel_idx      = idx_q - IDXW'(1);
        case (state_q)
            ST_IDLE: begin
                sel_op       = op_in;
                sel_data     = i_data;
                sel_idx      = first_idx;
                char_valid_d = 1'b0;
                if (i_valid) begin
                    if (!known) begin
                        err_d = 1'b1;
                    end else if (op_in != OP_IDLE) begin
                        op_d         = op_in;
                        data_d       = i_data;
                        idx_d        = first_idx;
                        char_d       = cur_char;
                        char_valid_d = 1'b1;
                        state_d      = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (i_char_ready) begin
                    if (idx_q == '0) begin
                        char_d  = ASCII_SPACE;
                        state_d = ST_SEP;
                    end else begin
                        idx_d  = idx_q - IDXW'(1);
                        char_d = cur_char;
                    end
                end
            end
            ST_SEP: begin
                if (i_char_ready) begin
                    char_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                char_valid_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_IDLE;
            data_q       <= '0;
            idx_q        <= '0;
            o_char       <= 8'h00;
            o_char_valid <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            data_q       <= data_d;
            idx_q        <= idx_d;
            o_char       <= char_d;
            o_char_valid <= char_valid_d;
            o_err        <= err_d;
        end
    end

endmodule
